// File: rtl/sme_bank_lsu.sv
// Share-bank load/store sequencer: one word transaction per instruction, IDLE->REQ->RSP->DONE.
// Best case accept-to-done is 3 cycles; ready only in IDLE, request held until mem_gnt.
module sme_bank_lsu #(
    parameter int XLEN = 32
) (
    input  logic            g_clk,
    input  logic            g_reset,
    input  logic            flush,
    input  logic            valid,
    output logic            ready,
    input  logic            op_load,
    input  logic            op_store,
    input  logic [XLEN-1:0] addr,
    input  logic [3:0]      rd_addr,
    output logic            bank_read,
    input  logic [XLEN-1:0] bank_rdata,
    output logic            bank_wen,
    output logic [3:0]      bank_waddr,
    output logic [XLEN-1:0] bank_wdata,
    output logic            mem_req,
    input  logic            mem_gnt,
    output logic            mem_wen,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    output logic [3:0]      mem_strb,
    input  logic            mem_rsp_valid,
    input  logic [XLEN-1:0] mem_rsp_rdata,
    input  logic            mem_rsp_error,
    output logic            done,
    output logic            error
);
    localparam int XL = XLEN - 1;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_RSP, S_DONE} state_t;

    state_t        state_q, state_d;
    logic [XL:2]   addr_q, addr_d;
    logic [XL:0]   data_q, data_d;
    logic [3:0]    rd_q, rd_d;
    logic          load_q, load_d;
    logic          err_q, err_d;
    logic          flushed_q, flushed_d;
    logic          accept;

    assign ready     = (state_q == S_IDLE) && !g_reset;
    assign accept    = valid && ready && (op_load ^ op_store) && !flush;
    assign bank_read = accept && op_store;

    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            data_q    <= '0;
            rd_q      <= '0;
            load_q    <= 1'b0;
            err_q     <= 1'b0;
            flushed_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            rd_q      <= rd_d;
            load_q    <= load_d;
            err_q     <= err_d;
            flushed_q <= flushed_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        data_d    = data_q;
        rd_d      = rd_q;
        load_d    = load_q;
        err_d     = err_q;
        flushed_d = flushed_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    addr_d    = addr[XL:2];
                    rd_d      = rd_addr;
                    load_d    = op_load;
                    flushed_d = 1'b0;
                    if (op_store) data_d = bank_rdata;
                    // Misaligned accesses never reach the bus; report straight away.
                    err_d   = (addr[1:0] != 2'b00);
                    state_d = (addr[1:0] != 2'b00) ? S_DONE : S_REQ;
                end
            end
            S_REQ: begin
                if (mem_gnt) begin
                    // A flush racing the grant still has a transaction in flight.
                    if (flush) flushed_d = 1'b1;
                    state_d = S_RSP;
                end else if (flush) begin
                    state_d = S_IDLE;
                end
            end
            S_RSP: begin
                if (flush) flushed_d = 1'b1;
                if (mem_rsp_valid) begin
                    data_d  = mem_rsp_rdata;
                    err_d   = mem_rsp_error;
                    state_d = (flushed_q || flush) ? S_IDLE : S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign mem_req    = (state_q == S_REQ);
    assign mem_wen    = mem_req && !load_q;
    assign mem_addr   = {addr_q, 2'b00};
    assign mem_wdata  = data_q;
    assign mem_strb   = mem_req ? 4'hF : 4'h0;

    assign done       = (state_q == S_DONE) && !flush;
    assign error      = done && err_q;
    assign bank_wen   = done && load_q && !err_q;
    assign bank_waddr = rd_q;
    assign bank_wdata = data_q;

endmodule

// File: tb/tb_sme_bank_lsu.sv
// Scoreboard bench for sme_bank_lsu: a memory responder with programmable grant/response delay.
module tb_sme_bank_lsu;
    logic        g_clk = 1'b0;
    logic        g_reset = 1'b1;
    logic        flush = 1'b0, valid = 1'b0, op_load = 1'b0, op_store = 1'b0;
    logic [31:0] addr = '0, bank_rdata = '0, mem_rsp_rdata = '0;
    logic [3:0]  rd_addr = '0;
    logic        mem_gnt = 1'b0, mem_rsp_valid = 1'b0, mem_rsp_error = 1'b0;
    logic        ready, bank_read, bank_wen, mem_req, mem_wen, done, error;
    logic [3:0]  bank_waddr, mem_strb;
    logic [31:0] bank_wdata, mem_addr, mem_wdata;

    sme_bank_lsu #(.XLEN(32)) dut (
        .g_clk(g_clk), .g_reset(g_reset), .flush(flush), .valid(valid), .ready(ready),
        .op_load(op_load), .op_store(op_store), .addr(addr), .rd_addr(rd_addr),
        .bank_read(bank_read), .bank_rdata(bank_rdata), .bank_wen(bank_wen),
        .bank_waddr(bank_waddr), .bank_wdata(bank_wdata), .mem_req(mem_req),
        .mem_gnt(mem_gnt), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_strb(mem_strb), .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata),
        .mem_rsp_error(mem_rsp_error), .done(done), .error(error)
    );

    always #5 g_clk = ~g_clk;

    typedef struct { logic [31:0] addr; logic wen; logic [31:0] wdata; } req_exp_t;
    typedef struct { logic err; logic wen; logic [3:0] waddr; logic [31:0] wdata; } done_exp_t;

    req_exp_t  req_q[$];
    done_exp_t done_q[$];

    int total = 0, bad = 0;
    int gnt_delay = 0, rsp_delay = 1;
    logic        rsp_err = 1'b0;
    logic [31:0] rsp_data = '0;
    int req_cycles = 0, done_cnt = 0, bread_cnt = 0;
    int n;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Memory responder: grant after gnt_delay stall cycles, respond rsp_delay cycles after grant.
    initial begin : responder
        int gcnt, rcnt;
        bit rsp_wait;
        gcnt = 0; rcnt = 0; rsp_wait = 0;
        forever begin
            @(negedge g_clk);
            mem_gnt = 1'b0;
            mem_rsp_valid = 1'b0;
            if (rsp_wait) begin
                rcnt++;
                if (rcnt >= rsp_delay) begin
                    mem_rsp_valid = 1'b1;
                    mem_rsp_rdata = rsp_data;
                    mem_rsp_error = rsp_err;
                    rsp_wait = 0;
                end
            end else if (mem_req) begin
                req_cycles++;
                if (req_q.size() == 0) chk("req_unexpected", 32'd1, 32'd0);
                else begin
                    chk("mem_addr", mem_addr, req_q[0].addr);
                    chk("mem_wen", {31'd0, mem_wen}, {31'd0, req_q[0].wen});
                    chk("mem_strb", {28'd0, mem_strb}, 32'hF);
                    if (req_q[0].wen) chk("mem_wdata", mem_wdata, req_q[0].wdata);
                end
                if (gcnt >= gnt_delay) begin
                    mem_gnt = 1'b1;
                    gcnt = 0; rcnt = 0; rsp_wait = 1;
                    if (req_q.size() != 0) void'(req_q.pop_front());
                end else gcnt++;
            end else gcnt = 0;
        end
    end

    initial begin : monitor
        done_exp_t e;
        forever begin
            @(negedge g_clk);
            #1;
            if (bank_read) bread_cnt++;
            if (done) begin
                done_cnt++;
                if (done_q.size() == 0) chk("done_unexpected", 32'd1, 32'd0);
                else begin
                    e = done_q.pop_front();
                    chk("error", {31'd0, error}, {31'd0, e.err});
                    chk("bank_wen", {31'd0, bank_wen}, {31'd0, e.wen});
                    if (e.wen) begin
                        chk("bank_waddr", {28'd0, bank_waddr}, {28'd0, e.waddr});
                        chk("bank_wdata", bank_wdata, e.wdata);
                    end
                end
            end else if (bank_wen) chk("stray_bank_wen", 32'd1, 32'd0);
        end
    end

    task automatic issue(input logic ld, input logic st, input logic [31:0] a,
                         input logic [3:0] rd, input logic [31:0] rdata);
        logic acc;
        @(negedge g_clk);
        valid = 1'b1; op_load = ld; op_store = st; addr = a; rd_addr = rd; bank_rdata = rdata;
        acc = (ld ^ st) && !flush;
        if (acc) begin
            if (a[1:0] != 2'b00) done_q.push_back('{1'b1, 1'b0, rd, 32'd0});
            else begin
                req_q.push_back('{a & 32'hFFFF_FFFC, st, rdata});
                done_q.push_back('{rsp_err, ld && !rsp_err, rd, rsp_data});
            end
        end
        #1;
        chk("ready_offer", {31'd0, ready}, 32'd1);
        chk("bank_read", {31'd0, bank_read}, {31'd0, acc && st});
        @(posedge g_clk);
        #1;
        valid = 1'b0; op_load = 1'b0; op_store = 1'b0; bank_rdata = 32'hA5A5_5A5A;
    endtask

    // Returns the number of negedges until ready is seen high (bounded).
    task automatic wait_ready(output int cnt);
        cnt = 0;
        do begin
            @(negedge g_clk);
            #1;
            cnt++;
        end while (!ready && cnt < 50);
        if (!ready) chk("ready_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int b0, r0, d0;
        repeat (3) @(negedge g_clk);
        #1;
        chk("rst_ready", {31'd0, ready}, 32'd0);
        chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        g_reset = 1'b0;
        #1;
        chk("rst_ready_rel", {31'd0, ready}, 32'd1);

        // Best-case load
        gnt_delay = 0; rsp_delay = 1; rsp_err = 0; rsp_data = 32'hDEADBEEF;
        issue(1, 0, 32'h1000, 4'd5, 32'h0);
        wait_ready(n);
        chk("load_latency", n, 4);

        // Store with delayed grant
        gnt_delay = 3; rsp_data = 32'h0BAD_F00D; b0 = bread_cnt;
        issue(0, 1, 32'h2004, 4'd2, 32'h12345678);
        wait_ready(n);
        chk("bank_read_once", bread_cnt - b0, 1);

        // Misaligned load
        gnt_delay = 0; r0 = req_cycles;
        issue(1, 0, 32'h1002, 4'd3, 32'h0);
        wait_ready(n);
        chk("misalign_latency", n, 2);
        chk("misalign_no_req", req_cycles - r0, 0);

        // Bus error on load
        rsp_err = 1; rsp_data = 32'h5555_AAAA;
        issue(1, 0, 32'h3008, 4'd7, 32'h0);
        wait_ready(n);
        rsp_err = 0;

        // Flush while waiting for the response
        rsp_delay = 3; rsp_data = 32'h7777_0001; d0 = done_cnt;
        issue(1, 0, 32'h4000, 4'd9, 32'h0);
        done_q.delete();
        @(negedge g_clk);
        @(negedge g_clk); flush = 1'b1;
        @(negedge g_clk); flush = 1'b0;
        wait_ready(n);
        chk("flush_rsp_ready", n, 2);
        repeat (2) @(negedge g_clk);
        chk("flush_rsp_no_done", done_cnt - d0, 0);
        rsp_delay = 1;

        // Flush in REQ before grant
        gnt_delay = 5; d0 = done_cnt;
        issue(1, 0, 32'h5000, 4'd1, 32'h0);
        done_q.delete();
        @(negedge g_clk); flush = 1'b1;
        @(negedge g_clk); flush = 1'b0;
        #1;
        chk("flush_req_drop", {31'd0, mem_req}, 32'd0);
        chk("flush_req_ready", {31'd0, ready}, 32'd1);
        req_q.delete();

        // Reset during REQ
        issue(0, 1, 32'h6000, 4'd1, 32'hCAFE_0001);
        @(negedge g_clk); g_reset = 1'b1;
        @(negedge g_clk);
        #1;
        chk("reset_req_drop", {31'd0, mem_req}, 32'd0);
        chk("reset_ready_low", {31'd0, ready}, 32'd0);
        g_reset = 1'b0;
        #1;
        chk("reset_ready_high", {31'd0, ready}, 32'd1);
        req_q.delete(); done_q.delete();

        // Illegal op encodings and flush in IDLE are never accepted
        gnt_delay = 0; r0 = req_cycles; d0 = done_cnt;
        issue(1, 1, 32'h7000, 4'd4, 32'h0);
        issue(0, 0, 32'h7004, 4'd4, 32'h0);
        flush = 1'b1;
        issue(1, 0, 32'h7008, 4'd4, 32'h0);
        flush = 1'b0;
        repeat (4) @(negedge g_clk);
        chk("illegal_no_req", req_cycles - r0, 0);
        chk("illegal_no_done", done_cnt - d0, 0);

        // Back-to-back loads after all of the above
        rsp_data = 32'h0102_0304;
        issue(1, 0, 32'h8000, 4'd15, 32'h0);
        wait_ready(n);
        rsp_data = 32'hF0E0_D0C0;
        issue(1, 0, 32'h800C, 4'd0, 32'h0);
        wait_ready(n);

        repeat (3) @(negedge g_clk);
        chk("done_q_empty", done_q.size(), 0);
        chk("req_q_empty", req_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
endmodule

// File: doc/sme_bank_lsu.md
Name: sme_bank_lsu

Overview:
- Load/store sequencer for SME share banks. It sits directly upstream of the SME share-state block.
- Executes one word-sized memory transaction per share-bank load or store instruction.
- Loads: drives the bank write port (bank_wen/bank_waddr/bank_wdata) with returned memory data.
- Stores: pulses bank_read, captures bank_rdata and writes it to memory.
- Bank selection is decoded downstream from SMECTL.b; this block does not see it.

Parameters:
- XLEN, 32, data/address width; XL = XLEN-1.

Ports:
- g_clk  in  1  global clock
- g_reset  in  1  reset; synchronous, active-high
- flush  in  1  discard in-flight instruction
- valid  in  1  new instruction offered
- ready  out  1  instruction accepted when valid&&ready
- op_load  in  1  load word into share bank
- op_store  in  1  store word from share bank
- addr  in  XLEN  byte address
- rd_addr  in  4  bank register written by load
- bank_read  out  1  request bank_rdata (store)
- bank_rdata  in  XLEN  bank read data, combinational from share state
- bank_wen  out  1  bank write strobe
- bank_waddr  out  4  bank write register
- bank_wdata  out  XLEN  bank write data
- mem_req  out  1  memory request
- mem_gnt  in  1  request accepted
- mem_wen  out  1  1=write
- mem_addr  out  XLEN  word-aligned address
- mem_wdata  out  XLEN  store data
- mem_strb  out  4  byte strobes
- mem_rsp_valid  in  1  response present
- mem_rsp_rdata  in  XLEN  load data
- mem_rsp_error  in  1  bus error
- done  out  1  instruction complete pulse
- error  out  1  with done: misaligned or bus error

Behaviour:
- States: IDLE, REQ, RSP, DONE. All registered outputs reset to 0 and state resets to IDLE.
- ready=1 only in IDLE with g_reset low.
- Accept condition: valid && ready && (op_load ^ op_store) && !flush.
  - On accept, capture addr, rd_addr and op.
  - If op_load and op_store are both 0 or both 1, the instruction is not accepted and no state changes.
- bank_read = accept && op_store, combinational in the accept cycle only. bank_rdata is latched into the wdata register that same cycle.
- Misalignment: if addr[1:0] != 0 on accept, go to DONE with error pending. No memory request is issued.
- Otherwise IDLE -> REQ.
- REQ:
  - mem_req=1.
  - mem_addr={addr[XL:2],2'b00}, mem_wen=op_store, mem_strb=4'hF, mem_wdata=captured data.
  - All of these are held stable until mem_gnt.
  - On mem_gnt -> RSP, and mem_req drops the next cycle.
- RSP:
  - Wait for mem_rsp_valid.
  - On response, latch mem_rsp_rdata and mem_rsp_error -> DONE.
  - The response may arrive the cycle after gnt at the earliest.
- DONE (one cycle):
  - done=1 and error=latched error.
  - bank_wen = op_load && !error, with bank_waddr=captured rd_addr and bank_wdata=latched data.
  - Then -> IDLE.
- Best-case latency (gnt in REQ's first cycle, response next cycle): accept at cycle 0, REQ at 1, RSP at 2, DONE at 3, IDLE/ready at 4.
- Flush:
  - IDLE: blocks acceptance.
  - REQ before gnt: -> IDLE next cycle and mem_req deasserts. Flush in the same cycle as gnt counts as granted.
  - RSP: set a flushed flag and keep waiting for the response, because an outstanding transaction is never abandoned. On response -> IDLE with no done and no bank_wen.
  - DONE: suppresses done, error and bank_wen, then -> IDLE.
- Reset mid-transaction: state returns to IDLE and the flushed flag clears. Any late response is ignored because mem_rsp_valid is only sampled in RSP.
- Only one outstanding transaction; no buffering of new instructions.

Test Plan:
- Load rd_addr=5, addr=0x1000; mem_gnt in REQ's first cycle; response one cycle later with rdata=0xDEADBEEF -> mem_addr=0x1000, mem_wen=0, strb=F; at cycle 3 bank_wen=1, bank_waddr=5, bank_wdata=0xDEADBEEF, done=1, error=0; ready=1 at cycle 4.
- Store addr=0x2004, bank_rdata=0x12345678 in accept cycle -> bank_read=1 for exactly one cycle; mem_wen=1, mem_wdata=0x12345678; mem_gnt delayed 3 cycles with request fields stable; done=1, bank_wen=0.
- Load addr=0x1002 -> no mem_req; next cycle done=1, error=1, bank_wen=0.
- Load with mem_rsp_error=1 -> done=1, error=1, bank_wen=0.
- Flush asserted in RSP, response 2 cycles later -> no done, no bank_wen, ready=1 the cycle after the response.
- g_reset=1 during REQ -> next cycle mem_req=0, ready=1 after reset drops. Also: valid with op_load=op_store=1 -> never accepted.
